// File: rtl/control_step_sequencer_if.sv
// ---------------------------------------------------------------------------
// control_step_sequencer_if
//
// Purpose:
//   Bundles the control, opcode and status signals of the timing-step
//   sequencer. The clock and the active-low reset stay outside the bundle
//   as plain ports of the sequencer.
//
// Signals:
//   clock_enable    master->slave  when low, every sequencer register holds
//   start           master->slave  level; begin/resume from STOPPED or HALTED
//   halt            master->slave  level; stop at the next instruction boundary
//   end_step        master->slave  decode-driven early end of the instruction
//   opcode_in       master->slave  opcode field from the instruction register
//   t_step          slave->master  one-hot step lines, zero when not running
//   step_index      slave->master  binary index of the active step
//   opcode_latched  slave->master  opcode held for the execute steps
//   instr_done      slave->master  one enabled-cycle pulse per boundary
//   running         slave->master  high in RUN
//   halted          slave->master  high in HALTED
//   instr_count     slave->master  retired instructions, wraps
//
// Modports:
//   master - the controlling side (drives the requests, observes status)
//   slave  - the sequencer itself
// ---------------------------------------------------------------------------
interface control_step_sequencer_if #(
    parameter int NUM_STEPS        = 7,
    parameter int STEP_INDEX_WIDTH = 3,
    parameter int OPCODE_WIDTH     = 4,
    parameter int COUNT_WIDTH      = 16
);

    logic                        clock_enable;
    logic                        start;
    logic                        halt;
    logic                        end_step;
    logic [OPCODE_WIDTH-1:0]     opcode_in;

    logic [NUM_STEPS-1:0]        t_step;
    logic [STEP_INDEX_WIDTH-1:0] step_index;
    logic [OPCODE_WIDTH-1:0]     opcode_latched;
    logic                        instr_done;
    logic                        running;
    logic                        halted;
    logic [COUNT_WIDTH-1:0]      instr_count;

    modport master (
        output clock_enable,
        output start,
        output halt,
        output end_step,
        output opcode_in,
        input  t_step,
        input  step_index,
        input  opcode_latched,
        input  instr_done,
        input  running,
        input  halted,
        input  instr_count
    );

    modport slave (
        input  clock_enable,
        input  start,
        input  halt,
        input  end_step,
        input  opcode_in,
        output t_step,
        output step_index,
        output opcode_latched,
        output instr_done,
        output running,
        output halted,
        output instr_count
    );

endinterface

// File: rtl/control_step_sequencer.sv
// ---------------------------------------------------------------------------
// control_step_sequencer
//
// Purpose:
//   Timing-step generator for the processor control unit. Produces the
//   one-hot T-step lines and the latched opcode that feed the decode AND
//   gates, sequences the fetch/execute micro-steps, ends an instruction
//   early when decode requests it, handles run/halt control and counts
//   retired instructions.
//
// Ports:
//   clock    in   rising-edge system clock
//   reset_n  in   asynchronous, active-low reset
//   bus      slave side of control_step_sequencer_if:
//              inputs  clock_enable, start, halt, end_step, opcode_in
//              outputs t_step, step_index, opcode_latched, instr_done,
//                      running, halted, instr_count
//
// All outputs come straight from registers; there is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module control_step_sequencer #(
    parameter int NUM_STEPS        = 7,
    parameter int STEP_INDEX_WIDTH = 3,
    parameter int OPCODE_WIDTH     = 4,
    parameter int FETCH_STEP       = 1,
    parameter int COUNT_WIDTH      = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    control_step_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUN     = 2'd1,
        HALTED  = 2'd2
    } state_t;

    localparam logic [NUM_STEPS-1:0] STEP0 = {{(NUM_STEPS-1){1'b0}}, 1'b1};

    // Registered state
    state_t                      state;
    logic [NUM_STEPS-1:0]        t_step;
    logic [STEP_INDEX_WIDTH-1:0] step_index;
    logic [OPCODE_WIDTH-1:0]     opcode_latched;
    logic                        instr_done;
    logic [COUNT_WIDTH-1:0]      instr_count;
    logic                        halt_pending;

    // Next-state values
    state_t                      state_next;
    logic [NUM_STEPS-1:0]        t_step_next;
    logic [STEP_INDEX_WIDTH-1:0] step_index_next;
    logic [OPCODE_WIDTH-1:0]     opcode_latched_next;
    logic                        instr_done_next;
    logic [COUNT_WIDTH-1:0]      instr_count_next;
    logic                        halt_pending_next;
    logic                        boundary;
    logic                        stop_here;

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_next          = state;
        t_step_next         = t_step;
        step_index_next     = step_index;
        opcode_latched_next = opcode_latched;
        instr_done_next     = 1'b0;          // the done pulse lasts one enabled cycle
        instr_count_next    = instr_count;
        halt_pending_next   = halt_pending;
        boundary            = 1'b0;
        stop_here           = 1'b0;

        case (state)
            STOPPED: begin
                // Only start matters here; halt/end_step are not sampled.
                if (bus.start) begin
                    state_next      = RUN;
                    t_step_next     = STEP0;
                    step_index_next = '0;
                end
            end

            RUN: begin
                if (!$onehot(t_step)) begin
                    // Corrupted step register: restart the instruction at
                    // step 0 without retiring anything.
                    t_step_next       = STEP0;
                    step_index_next   = '0;
                    halt_pending_next = halt_pending | bus.halt;
                end else begin
                    if (t_step[FETCH_STEP]) begin
                        opcode_latched_next = bus.opcode_in;
                    end

                    // End-step and last-step on the same edge are one boundary.
                    boundary  = bus.end_step | t_step[NUM_STEPS-1];
                    stop_here = halt_pending | bus.halt;

                    if (boundary) begin
                        instr_done_next   = 1'b1;
                        instr_count_next  = instr_count + 1'b1;
                        halt_pending_next = 1'b0;
                        step_index_next   = '0;
                        if (stop_here) begin
                            state_next  = HALTED;
                            t_step_next = '0;
                        end else begin
                            t_step_next = STEP0;
                        end
                    end else begin
                        t_step_next       = t_step << 1;
                        step_index_next   = step_index + 1'b1;
                        halt_pending_next = stop_here;
                    end
                end
            end

            HALTED: begin
                // A held halt keeps the block stopped even with start high.
                if (bus.start && !bus.halt) begin
                    state_next      = RUN;
                    t_step_next     = STEP0;
                    step_index_next = '0;
                end
            end

            default: begin
                state_next        = STOPPED;
                t_step_next       = '0;
                step_index_next   = '0;
                halt_pending_next = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Register stage
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= STOPPED;
            t_step         <= '0;
            step_index     <= '0;
            opcode_latched <= '0;
            instr_done     <= 1'b0;
            instr_count    <= '0;
            halt_pending   <= 1'b0;
        end else if (bus.clock_enable) begin
            state          <= state_next;
            t_step         <= t_step_next;
            step_index     <= step_index_next;
            opcode_latched <= opcode_latched_next;
            instr_done     <= instr_done_next;
            instr_count    <= instr_count_next;
            halt_pending   <= halt_pending_next;
        end
    end

    assign bus.t_step         = t_step;
    assign bus.step_index     = step_index;
    assign bus.opcode_latched = opcode_latched;
    assign bus.instr_done     = instr_done;
    assign bus.instr_count    = instr_count;
    assign bus.running        = (state == RUN);
    assign bus.halted         = (state == HALTED);

endmodule

// File: tb/tb_control_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_step_sequencer
//
// Directed bench for control_step_sequencer: a linear sequence of stimulus
// steps with hand-computed expectations, checked by immediate assertions.
// Inputs change #1 after a rising edge; outputs are sampled at that point.
// ---------------------------------------------------------------------------
module tb_control_step_sequencer;

    localparam int NUM_STEPS        = 7;
    localparam int STEP_INDEX_WIDTH = 3;
    localparam int OPCODE_WIDTH     = 4;
    localparam int FETCH_STEP       = 1;
    localparam int COUNT_WIDTH      = 16;

    logic clock;
    logic reset_n;

    int n_cmp;
    int n_bad;

    control_step_sequencer_if #(
        .NUM_STEPS        (NUM_STEPS),
        .STEP_INDEX_WIDTH (STEP_INDEX_WIDTH),
        .OPCODE_WIDTH     (OPCODE_WIDTH),
        .COUNT_WIDTH      (COUNT_WIDTH)
    ) bus ();

    control_step_sequencer #(
        .NUM_STEPS        (NUM_STEPS),
        .STEP_INDEX_WIDTH (STEP_INDEX_WIDTH),
        .OPCODE_WIDTH     (OPCODE_WIDTH),
        .FETCH_STEP       (FETCH_STEP),
        .COUNT_WIDTH      (COUNT_WIDTH)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full status check while running at step k.
    task automatic chk_run(input string tag, input int k, input logic done,
                           input logic [15:0] cnt);
        chk({tag, "_tstep"}, 64'(bus.t_step), 64'(1) << k);
        chk({tag, "_idx"},   64'(bus.step_index), 64'(k));
        chk({tag, "_done"},  64'(bus.instr_done), 64'(done));
        chk({tag, "_run"},   64'(bus.running), 64'(1));
        chk({tag, "_halt"},  64'(bus.halted), 64'(0));
        chk({tag, "_cnt"},   64'(bus.instr_count), 64'(cnt));
    endtask

    // Status check while not running (STOPPED or HALTED).
    task automatic chk_idle(input string tag, input logic hlt, input logic done,
                            input logic [15:0] cnt);
        chk({tag, "_tstep"}, 64'(bus.t_step), 64'(0));
        chk({tag, "_idx"},   64'(bus.step_index), 64'(0));
        chk({tag, "_done"},  64'(bus.instr_done), 64'(done));
        chk({tag, "_run"},   64'(bus.running), 64'(0));
        chk({tag, "_halt"},  64'(bus.halted), 64'(hlt));
        chk({tag, "_cnt"},   64'(bus.instr_count), 64'(cnt));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset_n          = 1'b1;
        bus.clock_enable = 1'b1;
        bus.start        = 1'b0;
        bus.halt         = 1'b0;
        bus.end_step     = 1'b0;
        bus.opcode_in    = 4'h3;

        // Reset asserted away from any clock edge.
        #1 reset_n = 1'b0;
        #1;
        chk_idle("reset", 1'b0, 1'b0, 16'd0);
        chk("reset_opc", 64'(bus.opcode_latched), 64'(0));
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk_idle("stopped", 1'b0, 1'b0, 16'd0);

        // Start from STOPPED; halt is ignored there.
        bus.start = 1'b1;
        bus.halt  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.halt  = 1'b0;
        chk_run("go", 0, 1'b0, 16'd0);

        // Full instruction, opcode 4'hA presented only during step 1.
        for (int k = 1; k < NUM_STEPS; k++) begin
            bus.opcode_in = (k == 2) ? 4'hA : 4'h3;
            tick();
            chk_run($sformatf("seq%0d", k), k, 1'b0, 16'd0);
            if (k == 1) bus.opcode_in = 4'hA;
        end
        bus.opcode_in = 4'h3;
        chk("opc_after_fetch", 64'(bus.opcode_latched), 64'(4'hA));
        tick();
        chk_run("wrap1", 0, 1'b1, 16'd1);
        chk("opc_hold_boundary", 64'(bus.opcode_latched), 64'(4'hA));
        tick();
        chk_run("post1", 1, 1'b0, 16'd1);
        chk("opc_hold_step1", 64'(bus.opcode_latched), 64'(4'hA));
        tick();
        chk_run("s2", 2, 1'b0, 16'd1);
        chk("opc_relatch", 64'(bus.opcode_latched), 64'(4'h3));

        // Early termination at step 3, then end_step held through step 0.
        tick();
        chk_run("s3", 3, 1'b0, 16'd1);
        bus.end_step = 1'b1;
        tick();
        chk_run("endstep", 0, 1'b1, 16'd2);
        tick();
        chk_run("endstep_hold", 0, 1'b1, 16'd3);
        bus.end_step = 1'b0;
        tick();
        chk_run("endstep_rel", 1, 1'b0, 16'd3);

        // Halt pulsed at step 2 completes the instruction, then halts.
        tick();
        chk_run("h2", 2, 1'b0, 16'd3);
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        chk_run("h3", 3, 1'b0, 16'd3);
        tick();
        tick();
        tick();
        chk_run("h6", 6, 1'b0, 16'd3);
        tick();
        chk_idle("halted", 1'b1, 1'b1, 16'd4);
        tick();
        chk_idle("halted2", 1'b1, 1'b0, 16'd4);
        chk("opc_in_halt", 64'(bus.opcode_latched), 64'(4'h3));
        bus.start = 1'b1;
        bus.halt  = 1'b1;
        tick();
        chk_idle("start_and_halt", 1'b1, 1'b0, 16'd4);
        bus.halt = 1'b0;
        tick();
        bus.start = 1'b0;
        chk_run("resume", 0, 1'b0, 16'd4);

        // Clock enable low at step 4, then again while instr_done is high.
        for (int k = 1; k <= 4; k++) tick();
        chk_run("ce_s4", 4, 1'b0, 16'd4);
        bus.clock_enable = 1'b0;
        bus.end_step     = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_run($sformatf("ce_hold%0d", k), 4, 1'b0, 16'd4);
        end
        bus.end_step     = 1'b0;
        bus.clock_enable = 1'b1;
        tick();
        chk_run("ce_s5", 5, 1'b0, 16'd4);
        tick();
        tick();
        chk_run("ce_wrap", 0, 1'b1, 16'd5);
        bus.clock_enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_run($sformatf("ce_done%0d", k), 0, 1'b1, 16'd5);
        end
        bus.clock_enable = 1'b1;
        tick();
        chk_run("ce_done_rel", 1, 1'b0, 16'd5);

        // Asynchronous reset in the middle of step 5.
        for (int k = 2; k <= 5; k++) tick();
        chk_run("pre_rst", 5, 1'b0, 16'd5);
        #2 reset_n = 1'b0;
        #1;
        chk_idle("async_rst", 1'b0, 1'b0, 16'd0);
        chk("async_rst_opc", 64'(bus.opcode_latched), 64'(0));
        tick();
        reset_n = 1'b1;
        tick();
        chk_idle("rst_rel", 1'b0, 1'b0, 16'd0);

        // Counter wrap: every edge is a boundary with end_step tied high.
        bus.start = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.end_step = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        chk_run("cnt_max", 0, 1'b1, 16'hFFFF);
        tick();
        chk_run("cnt_wrap", 0, 1'b1, 16'h0000);
        bus.end_step = 1'b0;
        tick();
        chk_run("cnt_rel", 1, 1'b0, 16'h0000);

        // Halt raised on the boundary edge itself.
        bus.end_step = 1'b1;
        bus.halt     = 1'b1;
        tick();
        bus.end_step = 1'b0;
        bus.halt     = 1'b0;
        chk_idle("halt_at_bnd", 1'b1, 1'b1, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_step_sequencer.md
Name: control_step_sequencer

Overview:
- Timing-step generator for the prototype processor control unit.
- Produces the one-hot T-step lines and the latched opcode that feed the multi-input AND gate decode terms. Each gate ANDs one step line with opcode bits, with bubbles on the inverted bits.
- Sequences fetch/execute micro-steps and terminates an instruction early on decode request.
- Handles run/halt control and counts retired instructions.

Parameters:
- NUM_STEPS, 7: number of one-hot T-step lines. Legal range 2..16.
- STEP_INDEX_WIDTH, 3: width of the binary step index. Must satisfy 2^STEP_INDEX_WIDTH >= NUM_STEPS.
- OPCODE_WIDTH, 4: width of the opcode field.
- FETCH_STEP, 1: step at whose closing edge the opcode is latched. Must be < NUM_STEPS.
- COUNT_WIDTH, 16: width of the retired-instruction counter.

Ports:
- Clock  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-low reset.
- ClockEnable  in  1  when low, all registers hold.
- Start  in  1  level; begins or resumes execution from STOPPED or HALTED.
- Halt  in  1  level; requests a stop at the next instruction boundary.
- End_Step  in  1  decode-driven early termination of the current instruction.
- Opcode_In  in  OPCODE_WIDTH  opcode field from the instruction register bus.
- T_Step  out  NUM_STEPS  one-hot step lines to the decode AND gates; all-zero when not running.
- Step_Index  out  STEP_INDEX_WIDTH  binary index of the active step; 0 when not running.
- Opcode_Latched  out  OPCODE_WIDTH  opcode held for the execute steps.
- Instr_Done  out  1  one enabled-cycle pulse after each instruction boundary.
- Running  out  1  high in RUN.
- Halted  out  1  high in HALTED.
- Instr_Count  out  COUNT_WIDTH  retired instructions, wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset low (asynchronous): state STOPPED; T_Step=0; Step_Index=0; Opcode_Latched=0; Instr_Done=0; Running=0; Halted=0; Instr_Count=0; halt_pending=0.
- Every register updates only on a rising Clock edge with ClockEnable=1. With ClockEnable=0, all outputs hold, including an asserted Instr_Done.
- States: STOPPED, RUN, HALTED.
- STOPPED -> RUN when Start=1. The next cycle has T_Step=1 (step 0) and Running=1. All other inputs are ignored in STOPPED.
- RUN, normal advance: one-hot shifts left one bit per enabled edge; Step_Index increments with it.
- Boundary edge: any enabled edge where End_Step=1, or the active step is NUM_STEPS-1. At a boundary edge:
  - T_Step returns to step 0.
  - Instr_Done is set for the following cycle.
  - Instr_Count increments.
- End_Step and the last step together form a single boundary: Instr_Count increments by 1 only.
- Instr_Done clears at the next enabled edge unless that edge is also a boundary, e.g. End_Step held high at step 0.
- Opcode latch: at an enabled edge with T_Step[FETCH_STEP]=1, Opcode_Latched <= Opcode_In. It holds otherwise, including through HALTED and STOPPED.
- End_Step asserted at a step below FETCH_STEP still terminates; the opcode is not updated in that case.
- Halt:
  - Halt=1 on any enabled RUN edge sets the sticky halt_pending.
  - At a boundary edge with halt_pending=1, or Halt=1 on that same edge, the state goes to HALTED. T_Step=0, Step_Index=0, Running=0, Halted=1, and halt_pending clears.
  - Instr_Done still pulses and Instr_Count still increments for that instruction.
- HALTED -> RUN at step 0 when Start=1 and Halt=0. When Start and Halt are both 1, the block stays HALTED (Halt wins).
- Start in RUN is ignored.
- An illegal T_Step encoding (not one-hot while in RUN) recovers to step 0 at the next enabled edge without counting an instruction.
- Reset asserted mid-instruction returns immediately to the reset values. No Instr_Done is produced for the aborted instruction.
- Combinational outputs depend only on registers; no input-to-output combinational path.

Test Plan:
- Reset low, then release; Start=1 for one cycle -> T_Step sequence 0000001, 0000010, …, 1000000, then 0000001. Instr_Done is high exactly one cycle, coincident with the returned 0000001. Instr_Count=1.
- Opcode_In=4'hA during step 1, 4'h3 at all other times -> Opcode_Latched=4'hA from step 2 onward, and it stays 4'hA after the boundary until the next step-1 edge.
- End_Step=1 at step 3 -> next T_Step=0000001. Instr_Done pulses once, Instr_Count+1. Steps 4..6 never appear.
- Halt pulsed one cycle at step 2 -> sequencing continues to step 6, then Halted=1, T_Step=0, Instr_Count+1. Start=1 with Halt=1 stays HALTED; Start=1 with Halt=0 resumes at step 0.
- ClockEnable=0 for 5 cycles at step 4, and again while Instr_Done=1 -> T_Step, Step_Index and Instr_Done frozen; resumes exactly where it stopped.
- Instr_Count preset near 16'hFFFF by running 65535 instructions with End_Step tied high -> wraps to 16'h0000. Reset pulse low mid-step 5 -> all outputs 0 asynchronously, before the next Clock edge.
